// File: rtl/load_counter_pkg.sv
// Shared types for the load counter family.
// State encoding and default counter width.
package load_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/load_down_counter_if.sv
// Load handshake bundle for the down-counter.
// Master issues start values, slave accepts them.
interface load_down_counter_if
  import load_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_in;

  modport master (
    output load_valid,
    output load_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_in,
    output load_ready
  );

endinterface

// File: rtl/load_down_counter.sv
// Loadable down-counter/timer with terminal-count strobe.
// One-shot or periodic depending on AUTO_RELOAD.
module load_down_counter
  import load_counter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  load_down_counter_if.slave ld,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             accept;
  logic             run_tc;
  logic             run_dec;

  // Loads are only taken when idle/done and not being aborted.
  assign ld.load_ready = (state == IDLE || state == DONE)
                       && !abort && rst_n;

  assign accept  = ld.load_valid && ld.load_ready;
  assign run_tc  = (state == RUN) && en && !abort
                 && (counter_out == ONE);
  assign run_dec = (state == RUN) && en && !abort
                 && (counter_out > ONE);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State, count, reload value and strobe; abort wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter_out <= '0;
      reload      <= '0;
      tc_pulse    <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      unique case (1'b1)
        abort: begin
          state       <= IDLE;
          counter_out <= '0;
        end
        accept: begin
          counter_out <= ld.load_in;
          reload      <= ld.load_in;
          if (ld.load_in == '0) begin
            state    <= DONE;
            tc_pulse <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        run_tc: begin
          tc_pulse <= 1'b1;
          if (AUTO_RELOAD) begin
            counter_out <= reload;
          end else begin
            counter_out <= '0;
            state       <= DONE;
          end
        end
        run_dec: begin
          counter_out <= counter_out - ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_down_counter.sv
// Directed bench for load_down_counter.
// One-shot and auto-reload instances, scoreboarded per cycle.
module tb_load_down_counter;

  typedef struct packed {
    logic       sel;
    logic [3:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       en0, abort0, en1, abort1;
  logic [3:0] cnt0, cnt1;
  logic       busy0, done0, tc0;
  logic       busy1, done1, tc1;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  load_down_counter_if #(.WIDTH(4)) if0 ();
  load_down_counter_if #(.WIDTH(4)) if1 ();

  load_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .ld(if0.slave),
    .en(en0), .abort(abort0), .counter_out(cnt0),
    .busy(busy0), .done(done0), .tc_pulse(tc0)
  );

  load_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .ld(if1.slave),
    .en(en1), .abort(abort1), .counter_out(cnt1),
    .busy(busy1), .done(done1), .tc_pulse(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs,
                         input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e, o;
    e = exp_q.pop_front();
    if (e.sel) o = '{1'b1, cnt1, tc1, busy1, done1};
    else       o = '{1'b0, cnt0, tc0, busy0, done0};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed cnt=%0d tc=%b busy=%b done=%b expected cnt=%0d tc=%b busy=%b done=%b",
             tag, o.cnt, o.tc, o.busy, o.done,
             e.cnt, e.tc, e.busy, e.done);
    end
  endtask

  // Push expectation, advance one edge, then score.
  task automatic tick(input string tag, input logic sel,
                      input logic [3:0] c, input logic t,
                      input logic b, input logic d);
    exp_q.push_back('{sel, c, t, b, d});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0; abort0 = 1'b0; en1 = 1'b0; abort1 = 1'b0;
    if0.load_valid = 1'b0; if0.load_in = 4'd0;
    if1.load_valid = 1'b0; if1.load_in = 4'd0;

    #1;
    exp_q.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    compare("reset_state");
    chk_bit("reset_ready_low", if0.load_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_bit("idle_ready", if0.load_ready, 1'b1);

    // One-shot load of 5
    if0.load_valid = 1'b1; if0.load_in = 4'd5; en0 = 1'b1;
    tick("os_load5", 0, 4'd5, 0, 1, 0);
    if0.load_valid = 1'b0;
    chk_bit("run_ready_low", if0.load_ready, 1'b0);
    tick("os_4", 0, 4'd4, 0, 1, 0);
    tick("os_3", 0, 4'd3, 0, 1, 0);
    tick("os_2", 0, 4'd2, 0, 1, 0);
    tick("os_1", 0, 4'd1, 0, 1, 0);
    tick("os_tc", 0, 4'd0, 1, 0, 1);
    tick("os_done_hold", 0, 4'd0, 0, 0, 1);
    chk_bit("done_ready", if0.load_ready, 1'b1);

    // Zero load then back-to-back load in DONE
    if0.load_valid = 1'b1; if0.load_in = 4'd0;
    tick("zero_load", 0, 4'd0, 1, 0, 1);
    if0.load_in = 4'd2;
    tick("b2b_load2", 0, 4'd2, 0, 1, 0);
    if0.load_valid = 1'b0;
    tick("b2b_1", 0, 4'd1, 0, 1, 0);
    tick("b2b_tc", 0, 4'd0, 1, 0, 1);

    // Enable stalls and an ignored load during RUN
    if0.load_valid = 1'b1; if0.load_in = 4'd3;
    tick("stall_load3", 0, 4'd3, 0, 1, 0);
    if0.load_valid = 1'b0;
    en0 = 1'b1; tick("stall_en1a", 0, 4'd2, 0, 1, 0);
    en0 = 1'b0;
    if0.load_valid = 1'b1; if0.load_in = 4'd9;
    #1;
    chk_bit("run_ignores_load", if0.load_ready, 1'b0);
    tick("stall_en0a", 0, 4'd2, 0, 1, 0);
    if0.load_valid = 1'b0;
    en0 = 1'b1; tick("stall_en1b", 0, 4'd1, 0, 1, 0);
    en0 = 1'b0; tick("stall_en0b", 0, 4'd1, 0, 1, 0);
    en0 = 1'b1; tick("stall_tc", 0, 4'd0, 1, 0, 1);

    // Abort mid-count
    if0.load_valid = 1'b1; if0.load_in = 4'd10;
    tick("ab_load10", 0, 4'd10, 0, 1, 0);
    if0.load_valid = 1'b0;
    tick("ab_9", 0, 4'd9, 0, 1, 0);
    tick("ab_8", 0, 4'd8, 0, 1, 0);
    tick("ab_7", 0, 4'd7, 0, 1, 0);
    abort0 = 1'b1;
    tick("ab_idle", 0, 4'd0, 0, 0, 0);
    if0.load_valid = 1'b1; if0.load_in = 4'd6;
    #1;
    chk_bit("ab_ready_low", if0.load_ready, 1'b0);
    tick("ab_no_accept", 0, 4'd0, 0, 0, 0);
    abort0 = 1'b0;

    // Abort at count 1 with en high suppresses terminal count
    if0.load_in = 4'd1;
    tick("ab1_load1", 0, 4'd1, 0, 1, 0);
    if0.load_valid = 1'b0;
    abort0 = 1'b1;
    tick("ab1_no_tc", 0, 4'd0, 0, 0, 0);
    abort0 = 1'b0;
    en0 = 1'b0;

    // Periodic instance
    if1.load_valid = 1'b1; if1.load_in = 4'd3; en1 = 1'b1;
    tick("ar_load3", 1, 4'd3, 0, 1, 0);
    if1.load_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick("ar_2", 1, 4'd2, 0, 1, 0);
      tick("ar_1", 1, 4'd1, 0, 1, 0);
      tick("ar_reload", 1, 4'd3, 1, 1, 0);
    end
    tick("ar_2b", 1, 4'd2, 0, 1, 0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 1'b0});
    compare("async_reset");
    chk_bit("async_ready_low", if1.load_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("post_reset_idle", 1, 4'd0, 0, 0, 0);

    chk_bit("queue_empty", exp_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
